squeeze_output_stage: RTL and testbench

//  Downstream neighbour of the permute stage: takes one squeezed rate block (already

---
 rtl/squeeze_output_stage.sv | 129 ++++++++++++
 tb/tb_squeeze_output_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/squeeze_output_stage.sv
// Serialises one squeezed rate block into W-bit valid/ready words, trimming the final block.
// Optional build macro SQUEEZE_KEEP_EN adds a byte-valid data_keep output.
module squeeze_output_stage #(
  parameter int unsigned W                 = 64,
  parameter int unsigned RATE              = 1344,
  parameter int unsigned MAX_WORDS         = RATE / W,
  parameter logic [1:0]  SHAKE128_MODE_VEC = 2'b00,
  parameter logic [1:0]  SHAKE256_MODE_VEC = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RATE-1:0] rate_input,
  input  logic [1:0]      operation_mode,
  input  logic [31:0]     output_size_in,
  input  logic            last_block_in,
  input  logic            load_valid,
  output logic            load_ready,
  output logic [W-1:0]    data_out,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            data_last,
`ifdef SQUEEZE_KEEP_EN
  output logic [W/8-1:0]  data_keep,
`endif
  output logic            block_done
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam int unsigned LW = $clog2(W);
  localparam int unsigned SW = 33 - LW;

  localparam logic [CW-1:0] WORDS_128 = CW'(1344 / W);
  localparam logic [CW-1:0] WORDS_256 = CW'(1088 / W);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]      state_q;
  logic [RATE-1:0] hold_q;
  logic [CW-1:0]   remaining_q;
  logic [LW-1:0]   tail_q;
  logic            last_q;
  logic            done_q;

  logic [CW-1:0]   block_words;
  logic [SW-1:0]   size_words;
  logic            fits;
  logic [CW-1:0]   words_this;
  logic [LW-1:0]   tail_this;
  logic            final_word;
  logic            xfer;
  logic            load_fire;
  logic [W-1:0]    tail_mask;
  logic [W-1:0]    word;

  always_comb begin
    if (operation_mode == SHAKE256_MODE_VEC) begin
      block_words = WORDS_256;
    end else if (operation_mode == SHAKE128_MODE_VEC) begin
      block_words = WORDS_128;
    end else begin
      block_words = '0;
    end
    // ceil(size / W) without a 32-bit overflow on the +W-1 term
    size_words = {1'b0, output_size_in[31:LW]} + SW'(|output_size_in[LW-1:0]);
    fits       = size_words <= SW'(block_words);
    words_this = (last_block_in && fits) ? size_words[CW-1:0] : block_words;
    tail_this  = (last_block_in && fits) ? output_size_in[LW-1:0] : '0;
  end

  always_comb begin
    final_word = remaining_q == CW'(1);
    data_valid = state_q == STREAM;
    xfer       = data_valid & data_ready;
    load_ready = (state_q == IDLE) | (xfer & final_word);
    load_fire  = load_valid & load_ready;
    tail_mask  = ~({W{1'b1}} << tail_q);
    word       = hold_q[W-1:0];
    if (final_word && (tail_q != '0)) begin
      word = word & tail_mask;
    end
    data_out   = data_valid ? word : '0;
    data_last  = data_valid & final_word & last_q;
    block_done = done_q;
  end

`ifdef SQUEEZE_KEEP_EN
  logic [LW:0] keep_bytes;

  always_comb begin
    keep_bytes = ({1'b0, tail_q} + (LW+1)'(7)) >> 3;
    if (!data_valid) begin
      data_keep = '0;
    end else if (final_word && (tail_q != '0)) begin
      data_keep = ~({(W/8){1'b1}} << keep_bytes);
    end else begin
      data_keep = '1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      remaining_q <= '0;
      tail_q      <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // A dropped block (zero words) reports completion just like a streamed one
      done_q <= (xfer & final_word) | (load_fire & (words_this == '0));
      if (load_fire) begin
        hold_q      <= rate_input;
        remaining_q <= words_this;
        tail_q      <= tail_this;
        last_q      <= last_block_in;
        state_q     <= (words_this != '0) ? STREAM : IDLE;
      end else if (xfer) begin
        hold_q      <= hold_q >> W;
        remaining_q <= remaining_q - CW'(1);
        if (final_word) begin
          state_q <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_squeeze_output_stage.sv
// Randomised bench for squeeze_output_stage against a word-queue reference model.
module tb_squeeze_output_stage;

  localparam logic [1:0] M128 = 2'b00;
  localparam logic [1:0] M256 = 2'b01;

  logic          clk;
  logic          rst;
  logic [1343:0] rate_input;
  logic [1:0]    operation_mode;
  logic [31:0]   output_size_in;
  logic          last_block_in;
  logic          load_valid;
  logic          load_ready;
  logic [63:0]   data_out;
  logic          data_valid;
  logic          data_ready;
  logic          data_last;
  logic          block_done;
`ifdef SQUEEZE_KEEP_EN
  logic [7:0]    data_keep;
`endif

  squeeze_output_stage dut (
    .clk            (clk),
    .rst            (rst),
    .rate_input     (rate_input),
    .operation_mode (operation_mode),
    .output_size_in (output_size_in),
    .last_block_in  (last_block_in),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .data_last      (data_last),
`ifdef SQUEEZE_KEEP_EN
    .data_keep      (data_keep),
`endif
    .block_done     (block_done)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        endb;
    logic [7:0]  keep;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          loads_taken = 0;
  int          words_popped = 0;
  logic        done_exp = 0;
  logic        stall_chk = 0;
  logic [63:0] stall_word = '0;
  bit          ready_rand = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_words(input logic [1:0] mode, input logic [31:0] size,
                                     input logic last);
    int bw;
    longint cw;
    bw = (mode == M128) ? 21 : (mode == M256) ? 17 : 0;
    cw = (longint'(size) + 63) / 64;
    if (last && cw < bw) return int'(cw);
    return bw;
  endfunction

  function automatic void model_push(input logic [1343:0] rate, input logic [1:0] mode,
                                     input logic [31:0] size, input logic last);
    int nw, bw, tail;
    bit trimmed;
    exp_t e;
    bw = (mode == M128) ? 21 : (mode == M256) ? 17 : 0;
    nw = model_words(mode, size, last);
    trimmed = last && ((longint'(size) + 63) / 64 <= bw);
    tail = int'(size % 64);
    for (int k = 0; k < nw; k++) begin
      e.data = rate[64*k +: 64];
      e.keep = 8'hFF;
      if (k == nw - 1 && trimmed && tail != 0) begin
        e.data = e.data & ((64'd1 << tail) - 64'd1);
        e.keep = 8'((16'd1 << ((tail + 7) / 8)) - 16'd1);
      end
      e.last = last && (k == nw - 1);
      e.endb = (k == nw - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: compares every cycle at the falling edge, then advances the model
  always @(negedge clk) begin
    logic exp_lr, next_done;
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      done_exp  = 0;
      stall_chk = 0;
    end else begin
      exp_lr = (exp_q.size() == 0) || (exp_q.size() == 1 && data_ready);
      check("load_ready", 64'(load_ready), 64'(exp_lr));
      check("data_valid", 64'(data_valid), 64'(exp_q.size() != 0));
      check("block_done", 64'(block_done), 64'(done_exp));
      if (stall_chk) check("stall_hold", data_out, stall_word);
      stall_chk = 0;
      next_done = 0;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("data_last", 64'(data_last), 64'(e.last));
        if (data_ready) begin
          check("data_out", data_out, e.data);
`ifdef SQUEEZE_KEEP_EN
          check("data_keep", 64'(data_keep), 64'(e.keep));
`endif
          next_done = e.endb;
          void'(exp_q.pop_front());
          words_popped++;
        end else begin
          stall_chk  = 1;
          stall_word = data_out;
        end
      end else begin
        check("data_last_idle", 64'(data_last), 64'd0);
      end
      if (load_valid && exp_lr) begin
        if (model_words(operation_mode, output_size_in, last_block_in) == 0) next_done = 1;
        model_push(rate_input, operation_mode, output_size_in, last_block_in);
        loads_taken++;
      end
      done_exp = next_done;
    end
  end

  always @(posedge clk) begin
    #1 data_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic wait_idle();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_block(input logic [1:0] mode, input logic [31:0] size, input logic last);
    int base, cyc;
    if (model_words(mode, size, last) == 0) wait_idle();
    for (int k = 0; k < 42; k++) rate_input[32*k +: 32] = $urandom();
    operation_mode = mode;
    output_size_in = size;
    last_block_in  = last;
    load_valid     = 1;
    base = loads_taken;
    cyc  = 0;
    while (loads_taken == base && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (loads_taken == base) check("load_timeout", 64'd0, 64'd1);
    load_valid = 0;
  endtask

  initial begin
    int base, cyc;
    logic [1:0]  m;
    logic [31:0] sz;
    rst = 0;
    rate_input = '0;
    operation_mode = M128;
    output_size_in = '0;
    last_block_in = 0;
    load_valid = 0;
    data_ready = 1;
    #1;
    check("rst_data_valid", 64'(data_valid), 64'd0);
    check("rst_data_last", 64'(data_last), 64'd0);
    check("rst_block_done", 64'(block_done), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Two full SHAKE128 blocks, streamed with no gap
    load_block(M128, 32'd2688, 1'b0);
    load_block(M128, 32'd2688, 1'b1);
    wait_idle();
    // Short SHAKE256 output, then a trimmed SHAKE128 tail
    load_block(M256, 32'd256, 1'b1);
    wait_idle();
    load_block(M128, 32'd100, 1'b1);
    wait_idle();
    // Full SHAKE256 block under random backpressure
    ready_rand = 1;
    load_block(M256, 32'd5000, 1'b0);
    wait_idle();
    // Back-to-back blocks, then dropped loads
    ready_rand = 0;
    load_block(M256, 32'd1088, 1'b0);
    load_block(M128, 32'd500, 1'b1);
    load_block(M128, 32'd0, 1'b1);
    load_block(2'b11, 32'd800, 1'b1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      ready_rand = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       m = 2'b11;
        1:       m = 2'b10;
        2, 3, 4: m = M128;
        default: m = M256;
      endcase
      case ($urandom_range(0, 3))
        0:       sz = $urandom_range(0, 200);
        1:       sz = $urandom_range(0, 1400);
        2:       sz = $urandom_range(1, 5000);
        default: sz = $urandom();
      endcase
      load_block(m, sz, 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // Reset in the middle of a block
    ready_rand = 0;
    base = words_popped;
    load_block(M128, 32'd5000, 1'b0);
    cyc = 0;
    while (words_popped - base < 7 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_block_reached", 64'(words_popped - base), 64'd7);
    rst = 0;
    #1;
    check("midrst_data_valid", 64'(data_valid), 64'd0);
    check("midrst_data_last", 64'(data_last), 64'd0);
    check("midrst_block_done", 64'(block_done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    load_block(M256, 32'd1088, 1'b1);
    wait_idle();

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
